// File: rtl/i2c_reg_target_if.sv
// Bus bundle between an I2C register target and its host:
// pin-level I2C plus the register-file write strobe and read port.
interface i2c_reg_target_if;
  logic       I2C_SCL;
  logic       I2C_SDA_IN;
  logic       I2C_SDA_OE;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  modport slave (
    input  I2C_SCL, I2C_SDA_IN, rd_data,
    output I2C_SDA_OE, wr_stb, wr_addr,
    output wr_data, rd_addr, busy
  );

  modport master (
    output I2C_SCL, I2C_SDA_IN, rd_data,
    input  I2C_SDA_OE, wr_stb, wr_addr,
    input  wr_data, rd_addr, busy
  );
endinterface

// File: rtl/i2c_reg_target.sv
// I2C target mapping [DEV+R/W, SUB, DATA...] transactions
// onto a register-file write strobe and combinational read port.
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         FILT     = 4
) (
  input logic iCLK,
  input logic iRST,
  i2c_reg_target_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK,
    WDATA, WDATA_ACK, RDATA, MACK, IGNORE
  } state_t;

  logic [1:0]      s1, s2, flt, flt_d;
  logic [1:0][3:0] fcnt;

  // bit 0 = SCL, bit 1 = SDA
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1    <= 2'b11;
      s2    <= 2'b11;
      flt   <= 2'b11;
      flt_d <= 2'b11;
      fcnt  <= '0;
    end else begin
      s1    <= {bus.I2C_SDA_IN, bus.I2C_SCL};
      s2    <= s1;
      flt_d <= flt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == flt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == 4'(FILT - 1)) begin
          flt[i]  <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  logic scl, sda, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop;

  assign scl      = flt[0];
  assign sda      = flt[1];
  assign scl_d    = flt_d[0];
  assign sda_d    = flt_d[1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start    = scl & scl_d & sda_d & ~sda;
  assign stop     = scl & scl_d & ~sda_d & sda;

  state_t     state, state_n;
  logic [3:0] bcnt, bcnt_n;
  logic [7:0] sh, sh_n, ptr, ptr_n;
  logic [7:0] waddr, waddr_n, wdata, wdata_n;
  logic       oe, oe_n, ack_on, ack_n;
  logic       stb, stb_n, busy, busy_n;
  logic [7:0] byte_in;
  logic       last;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state  <= IDLE;
      bcnt   <= '0;
      sh     <= '0;
      ptr    <= '0;
      waddr  <= '0;
      wdata  <= '0;
      oe     <= 1'b0;
      ack_on <= 1'b0;
      stb    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      bcnt   <= bcnt_n;
      sh     <= sh_n;
      ptr    <= ptr_n;
      waddr  <= waddr_n;
      wdata  <= wdata_n;
      oe     <= oe_n;
      ack_on <= ack_n;
      stb    <= stb_n;
      busy   <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    sh_n    = sh;
    ptr_n   = ptr;
    waddr_n = waddr;
    wdata_n = wdata;
    oe_n    = oe;
    ack_n   = ack_on;
    stb_n   = 1'b0;
    busy_n  = busy;
    byte_in = {sh[6:0], sda};
    last    = (bcnt == 4'd7);
    if (stb) ptr_n = ptr + 8'd1;
    if (start) begin
      state_n = ADDR;
      bcnt_n  = '0;
      oe_n    = 1'b0;
      ack_n   = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      oe_n    = 1'b0;
      ack_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR, SUB, WDATA: begin
          if (scl_rise) begin
            sh_n   = byte_in;
            bcnt_n = bcnt + 4'd1;
            if (last) begin
              bcnt_n = '0;
              if (state == ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_n = ADDR_ACK;
                  busy_n  = 1'b1;
                end else begin
                  state_n = IGNORE;
                  busy_n  = 1'b0;
                end
              end else if (state == SUB) begin
                ptr_n   = byte_in;
                state_n = SUB_ACK;
              end else begin
                stb_n   = 1'b1;
                waddr_n = ptr;
                wdata_n = byte_in;
                state_n = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, SUB_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              oe_n  = 1'b1;
              ack_n = 1'b1;
            end else begin
              oe_n   = 1'b0;
              ack_n  = 1'b0;
              bcnt_n = '0;
              if (state != ADDR_ACK) begin
                state_n = WDATA;
              end else if (sh[0]) begin
                // first read bit goes out on the ACK release edge
                sh_n    = bus.rd_data;
                oe_n    = ~bus.rd_data[7];
                state_n = RDATA;
              end else begin
                state_n = SUB;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bcnt_n = bcnt + 4'd1;
          end else if (scl_fall) begin
            if (bcnt == 4'd8) begin
              oe_n    = 1'b0;
              state_n = MACK;
            end else begin
              sh_n = {sh[6:0], sh[7]};
              oe_n = ~sh[6];
            end
          end
        end
        MACK: begin
          if (scl_rise && !ack_on) begin
            if (sda) begin
              state_n = IGNORE;
            end else begin
              ptr_n = ptr + 8'd1;
              ack_n = 1'b1;
            end
          end else if (scl_fall && ack_on) begin
            sh_n    = bus.rd_data;
            oe_n    = ~bus.rd_data[7];
            bcnt_n  = '0;
            ack_n   = 1'b0;
            state_n = RDATA;
          end
        end
        IGNORE: oe_n = 1'b0;
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.I2C_SDA_OE = oe;
  assign bus.wr_stb     = stb;
  assign bus.wr_addr    = waddr;
  assign bus.wr_data    = wdata;
  assign bus.rd_addr    = ptr;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Scoreboard bench: a bit-banged I2C master with a byte-level model;
// bus and strobe monitors pop expectations and compare.
module tb_i2c_reg_target;

  localparam int HALF = 16;

  typedef struct {
    bit         chk;
    logic [7:0] d;
    logic       a;
  } bus_exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_exp_t;

  logic clk, rst;
  logic scl_m, sda_m, glitch, init_en, mon_off;

  i2c_reg_target_if bus ();

  i2c_reg_target #(.DEV_ADDR(7'h39), .FILT(4)) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  assign bus.I2C_SCL    = scl_m | glitch;
  assign bus.I2C_SDA_IN = sda_m & ~bus.I2C_SDA_OE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] hmem [256];
  logic [7:0] mem_m [256];
  logic [7:0] model_ptr;
  bus_exp_t   exp_bus [$];
  wr_exp_t    exp_wr [$];
  logic [7:0] tx_data [$];
  int         total, passed;

  function automatic logic [7:0] init_val(logic [7:0] a);
    return (a * 8'd37) ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) hmem[i] <= init_val(8'(i));
    end else if (bus.wr_stb) begin
      hmem[bus.wr_addr] <= bus.wr_data;
    end
  end
  assign bus.rd_data = hmem[bus.rd_addr];

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
  endtask

  // Bus monitor: decodes bytes on the pins and checks each 9th bit.
  logic     p_scl, p_sda, in_txn, mb;
  int       nbit;
  logic [7:0] mbyte;
  bus_exp_t be;
  logic     oe_seen, busy_seen;

  initial begin
    p_scl = 1'b1; p_sda = 1'b1; in_txn = 1'b0; nbit = 0; mbyte = '0;
  end

  always @(negedge clk) begin
    mb = bus.I2C_SDA_IN;
    if (bus.I2C_SDA_OE) oe_seen = 1'b1;
    if (bus.busy) busy_seen = 1'b1;
    if (mon_off || rst) begin
      in_txn = 1'b0;
    end else if (scl_m && p_scl && p_sda && !mb) begin
      in_txn = 1'b1;
      nbit   = 0;
    end else if (scl_m && p_scl && !p_sda && mb) begin
      in_txn = 1'b0;
      nbit   = 0;
    end else if (scl_m && !p_scl && in_txn) begin
      if (nbit < 8) begin
        mbyte = {mbyte[6:0], mb};
        nbit++;
      end else begin
        nbit = 0;
        if (exp_bus.size() == 0) begin
          check("bus_extra_byte", 0, 1);
        end else begin
          be = exp_bus.pop_front();
          check("ack_bit", 32'(mb), 32'(be.a));
          if (be.chk) check("rd_byte", 32'(mbyte), 32'(be.d));
        end
      end
    end
    p_scl = scl_m;
    p_sda = mb;
  end

  wr_exp_t we;
  always @(negedge clk) begin
    if (!rst && bus.wr_stb) begin
      if (exp_wr.size() == 0) begin
        check("wr_extra_strobe", 0, 1);
      end else begin
        we = exp_wr.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(we.a));
        check("wr_data", 32'(bus.wr_data), 32'(we.d));
      end
    end
  end

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      wait_clk(HALF / 2); sda_m = 1'b1;
      wait_clk(HALF / 2); scl_m = 1'b1;
      wait_clk(HALF);
    end
    sda_m = 1'b0;
    wait_clk(HALF); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(HALF / 2); sda_m = 1'b0;
    wait_clk(HALF / 2); scl_m = 1'b1;
    wait_clk(HALF); sda_m = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic bit_out(logic b, bit glt);
    wait_clk(HALF / 2); sda_m = b;
    if (glt) begin
      wait_clk(2); glitch = 1'b1;
      wait_clk(1); glitch = 1'b0;
      wait_clk(HALF / 2 - 3);
    end else begin
      wait_clk(HALF / 2);
    end
    scl_m = 1'b1;
    wait_clk(HALF); scl_m = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] d, bit glt);
    for (int i = 7; i >= 0; i--) bit_out(d[i], glt && i == 3);
    bit_out(1'b1, 1'b0);
  endtask

  task automatic recv_byte(logic ack);
    for (int i = 0; i < 8; i++) bit_out(1'b1, 1'b0);
    bit_out(ack, 1'b0);
  endtask

  task automatic do_write(logic [7:0] sub, logic [6:0] dev, int glt_byte);
    bit ok;
    ok = (dev == 7'h39);
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    exp_bus.push_back('{1'b0, 8'h00, !ok});
    send_byte({dev, 1'b0}, 1'b0);
    @(negedge clk);
    check("busy_after_addr", 32'(bus.busy), 32'(ok));
    exp_bus.push_back('{1'b0, 8'h00, !ok});
    send_byte(sub, 1'b0);
    if (ok) model_ptr = sub;
    foreach (tx_data[i]) begin
      exp_bus.push_back('{1'b0, 8'h00, !ok});
      if (ok) begin
        exp_wr.push_back('{model_ptr, tx_data[i]});
        mem_m[model_ptr] = tx_data[i];
        model_ptr++;
      end
      send_byte(tx_data[i], i == glt_byte);
    end
    i2c_stop();
    wait_clk(4);
    @(negedge clk);
    check("busy_after_stop", 32'(bus.busy), 0);
    check("wr_pending", exp_wr.size(), 0);
    check("rd_addr_ptr", 32'(bus.rd_addr), 32'(model_ptr));
    if (!ok) begin
      check("oe_on_bad_addr", 32'(oe_seen), 0);
      check("busy_on_bad_addr", 32'(busy_seen), 0);
    end
    tx_data.delete();
  endtask

  task automatic do_read(logic [7:0] sub, int n);
    i2c_start();
    exp_bus.push_back('{1'b0, 8'h00, 1'b0});
    send_byte(8'h72, 1'b0);
    exp_bus.push_back('{1'b0, 8'h00, 1'b0});
    send_byte(sub, 1'b0);
    model_ptr = sub;
    i2c_start();
    exp_bus.push_back('{1'b0, 8'h00, 1'b0});
    send_byte(8'h73, 1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bus.push_back('{1'b1, mem_m[model_ptr], i == n - 1});
      recv_byte(i == n - 1);
      if (i != n - 1) model_ptr++;
    end
    @(negedge clk);
    check("oe_after_nack", 32'(bus.I2C_SDA_OE), 0);
    i2c_stop();
    wait_clk(4);
    @(negedge clk);
    check("busy_after_rd", 32'(bus.busy), 0);
    check("rd_addr_ptr", 32'(bus.rd_addr), 32'(model_ptr));
  endtask

  logic [7:0] rsub;
  logic [6:0] rdev;
  int         rn;

  initial begin
    total = 0; passed = 0;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    glitch = 1'b0; init_en = 1'b1; mon_off = 1'b0;
    model_ptr = '0;
    for (int i = 0; i < 256; i++) mem_m[i] = init_val(8'(i));
    wait_clk(5);
    @(negedge clk);
    check("rst_oe", 32'(bus.I2C_SDA_OE), 0);
    check("rst_wr_stb", 32'(bus.wr_stb), 0);
    check("rst_wr_addr", 32'(bus.wr_addr), 0);
    check("rst_wr_data", 32'(bus.wr_data), 0);
    check("rst_rd_addr", 32'(bus.rd_addr), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(posedge clk);
    rst = 1'b0; init_en = 1'b0;
    wait_clk(HALF);

    tx_data = '{8'h62};
    do_write(8'h17, 7'h39, -1);

    tx_data = '{8'hA1, 8'hB2, 8'hC3};
    do_write(8'hFE, 7'h39, -1);
    check("ptr_wrap", 32'(bus.rd_addr), 32'h01);

    tx_data = '{8'h62};
    do_write(8'h17, 7'h38, -1);

    tx_data = '{8'h61, 8'h30};
    do_write(8'h9D, 7'h39, -1);
    do_read(8'h9D, 2);

    // reset while the target holds the address ACK
    mon_off = 1'b1;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_out(1'(8'h72 >> i), 1'b0);
    wait_clk(HALF / 2); sda_m = 1'b1;
    wait_clk(HALF / 2); scl_m = 1'b1;
    wait_clk(HALF / 2);
    @(negedge clk);
    check("oe_in_ack", 32'(bus.I2C_SDA_OE), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("oe_async_rst", 32'(bus.I2C_SDA_OE), 0);
    check("busy_async_rst", 32'(bus.busy), 0);
    wait_clk(3);
    rst = 1'b0;
    model_ptr = '0;
    wait_clk(HALF); scl_m = 1'b0;
    wait_clk(HALF); scl_m = 1'b1;
    wait_clk(2 * HALF);
    @(negedge clk);
    check("rd_addr_after_rst", 32'(bus.rd_addr), 0);
    mon_off = 1'b0;
    wait_clk(2);
    tx_data = '{8'h5C};
    do_write(8'h40, 7'h39, -1);

    tx_data = '{8'h3C, 8'hE7};
    do_write(8'h22, 7'h39, 0);
    do_read(8'h22, 2);

    for (int t = 0; t < 12; t++) begin
      rsub = 8'($urandom);
      rn   = int'($urandom_range(1, 4));
      case ($urandom_range(0, 2))
        0: begin
          for (int k = 0; k < rn; k++) tx_data.push_back(8'($urandom));
          do_write(rsub, 7'h39, -1);
        end
        1: do_read(rsub, rn);
        default: begin
          rdev = 7'($urandom);
          if (rdev == 7'h39) rdev = 7'h3A;
          tx_data.push_back(8'($urandom));
          do_write(rsub, rdev, -1);
        end
      endcase
      wait_clk(HALF);
    end

    wait_clk(20);
    check("bus_queue_empty", exp_bus.size(), 0);
    check("wr_queue_empty", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
